// File: rtl/bisr_job_scheduler_pkg.sv
// Shared state encoding and fault-map helpers for the BISR job scheduler.
// The column check assumes the per-PE bit index is col*rows+row.
package bisr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        C_LAUNCH = 3'd1,
        C_BUSY   = 3'd2,
        C_RUN    = 3'd3,
        T_LAUNCH = 3'd4,
        T_WAIT   = 3'd5,
        T_EVAL   = 3'd6,
        ERROR    = 3'd7
    } sched_state_e;

    localparam int DEF_ROWS    = 4;
    localparam int DEF_COLS    = 4;
    localparam int MAX_PE      = 64;
    localparam int FAULT_CNT_W = $clog2(DEF_ROWS * DEF_COLS + 1);

    // One spare proxy per column: two or more failing PEs in a column cannot be repaired.
    function automatic logic col_multi_fault(input logic [MAX_PE-1:0] map,
                                             input int rows, input int cols);
        logic multi;
        int   cnt;
        multi = 1'b0;
        for (int c = 0; c < cols; c++) begin
            cnt = 0;
            for (int r = 0; r < rows; r++) begin
                cnt = cnt + int'(map[c * rows + r]);
            end
            if (cnt > 1) begin
                multi = 1'b1;
            end else begin
                multi = multi;
            end
        end
        return multi;
    endfunction

endpackage

// File: rtl/bisr_job_scheduler_fault_map_eval.sv
// Combinational fault-map evaluation: popcount of failing PEs and the
// per-column repairability check. The parent registers the results.
module fault_map_eval
    import bisr_sched_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int FCW  = $clog2(ROWS * COLS + 1)
) (
    input  logic [ROWS*COLS-1:0] fault_map,
    output logic [FCW-1:0]       fault_count,
    output logic                 unrepairable
);

    logic [FCW-1:0] count_s;

    // Population count of the failing-PE bits.
    always_comb begin
        count_s = {FCW{1'b0}};
        for (int i = 0; i < ROWS * COLS; i++) begin
            count_s = count_s + FCW'(fault_map[i]);
        end
    end

    assign fault_count  = count_s;
    assign unrepairable = col_multi_fault(MAX_PE'(fault_map), ROWS, COLS);

endmodule

// File: rtl/bisr_job_scheduler.sv
// Sequences matmul jobs into the systolic top, interleaves stop-the-world
// self-test passes, accumulates the PE fault map and keeps proxy repair enabled.
module bisr_job_scheduler
    import bisr_sched_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int TEST_INTERVAL = 8,
    parameter int TIMEOUT       = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             job_req,
    output logic                             job_ack,
    output logic                             job_done,
    input  logic                             force_test,
    input  logic                             clear_err,
    input  logic                             fsm_rdy,
    input  logic                             STW_complete,
    input  logic [ROWS*COLS-1:0]             STW_result_mat,
    output logic                             start_fsm,
    output logic                             bisr_en,
    output logic [ROWS*COLS-1:0]             fault_map,
    output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count,
    output logic                             unrepairable,
    output logic                             timeout_err,
    output logic                             busy
);

    localparam int NPE = ROWS * COLS;
    localparam int FCW = $clog2(NPE + 1);

    sched_state_e   state_r, state_next_s;
    logic [CNT_W-1:0] tmo_r, job_cnt_r;
    logic           test_pending_r;
    logic [NPE-1:0] cap_r, fault_map_r, merged_s;
    logic [FCW-1:0] fault_count_r, eval_count_s, count_next_s;
    logic           unrep_r, eval_unrep_s, timeout_err_r;
    logic           bisr_en_r, start_r, ack_r, done_r, busy_r;
    logic           start_s, ack_s, done_s, tmo_hit_s;
    logic           tmo_expired_s, counting_s, interval_hit_s, test_path_s, err_clear_s;

    assign merged_s       = fault_map_r | cap_r;
    assign tmo_expired_s  = (tmo_r == CNT_W'(TIMEOUT - 1));
    assign counting_s     = (state_r == C_LAUNCH) || (state_r == C_BUSY) || (state_r == C_RUN) ||
                            (state_r == T_LAUNCH) || (state_r == T_WAIT);
    assign interval_hit_s = done_s && (job_cnt_r == CNT_W'(TEST_INTERVAL - 1));
    assign test_path_s    = (state_next_s == T_LAUNCH) || (state_next_s == T_WAIT) ||
                            (state_next_s == T_EVAL);
    assign count_next_s   = (state_r == T_EVAL) ? eval_count_s : fault_count_r;
    assign err_clear_s    = (state_r == ERROR) && clear_err;

    fault_map_eval #(
        .ROWS (ROWS),
        .COLS (COLS),
        .FCW  (FCW)
    ) u_eval (
        .fault_map    (merged_s),
        .fault_count  (eval_count_s),
        .unrepairable (eval_unrep_s)
    );

    // Next-state decode with launch, done and timeout events.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        ack_s        = 1'b0;
        done_s       = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (test_pending_r) begin
                    state_next_s = T_LAUNCH;
                end else if (job_req) begin
                    state_next_s = C_LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            C_LAUNCH: begin
                if (fsm_rdy) begin
                    state_next_s = C_BUSY;
                    start_s      = 1'b1;
                    ack_s        = 1'b1;
                end else if (tmo_expired_s) begin
                    state_next_s = ERROR;
                    tmo_hit_s    = 1'b1;
                end else begin
                    state_next_s = C_LAUNCH;
                end
            end
            C_BUSY: begin
                if (!fsm_rdy) begin
                    state_next_s = C_RUN;
                end else if (tmo_expired_s) begin
                    state_next_s = ERROR;
                    tmo_hit_s    = 1'b1;
                end else begin
                    state_next_s = C_BUSY;
                end
            end
            C_RUN: begin
                if (fsm_rdy) begin
                    state_next_s = IDLE;
                    done_s       = 1'b1;
                end else if (tmo_expired_s) begin
                    state_next_s = ERROR;
                    tmo_hit_s    = 1'b1;
                end else begin
                    state_next_s = C_RUN;
                end
            end
            T_LAUNCH: begin
                if (fsm_rdy) begin
                    state_next_s = T_WAIT;
                    start_s      = 1'b1;
                end else if (tmo_expired_s) begin
                    state_next_s = ERROR;
                    tmo_hit_s    = 1'b1;
                end else begin
                    state_next_s = T_LAUNCH;
                end
            end
            T_WAIT: begin
                if (STW_complete) begin
                    state_next_s = T_EVAL;
                end else if (tmo_expired_s) begin
                    state_next_s = ERROR;
                    tmo_hit_s    = 1'b1;
                end else begin
                    state_next_s = T_WAIT;
                end
            end
            T_EVAL: begin
                if (eval_unrep_s) begin
                    state_next_s = ERROR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ERROR: begin
                if (clear_err) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ERROR;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; the timeout counter restarts on every state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            tmo_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                tmo_r <= {CNT_W{1'b0}};
            end else if (counting_s) begin
                tmo_r <= tmo_r + CNT_W'(1);
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

    // Job counter and pending self-test request; a fresh force_test outranks the T_EVAL clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt_r      <= {CNT_W{1'b0}};
            test_pending_r <= 1'b1;
        end else begin
            if (interval_hit_s) begin
                job_cnt_r <= {CNT_W{1'b0}};
            end else if (done_s) begin
                job_cnt_r <= job_cnt_r + CNT_W'(1);
            end else begin
                job_cnt_r <= job_cnt_r;
            end
            if (force_test || interval_hit_s) begin
                test_pending_r <= 1'b1;
            end else if (state_r == T_EVAL) begin
                test_pending_r <= 1'b0;
            end else begin
                test_pending_r <= test_pending_r;
            end
        end
    end

    // Self-test capture and the permanent fault map with its evaluated status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_r         <= {NPE{1'b0}};
            fault_map_r   <= {NPE{1'b0}};
            fault_count_r <= {FCW{1'b0}};
            unrep_r       <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r == T_WAIT) && STW_complete) begin
                cap_r <= STW_result_mat;
            end else begin
                cap_r <= cap_r;
            end
            if (state_r == T_EVAL) begin
                fault_map_r   <= merged_s;
                fault_count_r <= eval_count_s;
                unrep_r       <= eval_unrep_s;
            end else if (err_clear_s) begin
                unrep_r <= 1'b0;
            end else begin
                unrep_r <= unrep_r;
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end else if (err_clear_s) begin
                timeout_err_r <= 1'b0;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Registered handshake pulses, busy flag and repair enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_r   <= 1'b0;
            ack_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            bisr_en_r <= 1'b0;
        end else begin
            start_r   <= start_s;
            ack_r     <= ack_s;
            done_r    <= done_s;
            busy_r    <= (state_next_s != IDLE);
            bisr_en_r <= test_path_s || (count_next_s != {FCW{1'b0}});
        end
    end

    assign start_fsm    = start_r;
    assign job_ack      = ack_r;
    assign job_done     = done_r;
    assign busy         = busy_r;
    assign bisr_en      = bisr_en_r;
    assign fault_map    = fault_map_r;
    assign fault_count  = fault_count_r;
    assign unrepairable = unrep_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_bisr_job_scheduler.sv
// Directed bench for bisr_job_scheduler with a small systolic-top responder and
// a launch scoreboard holding the expected {job_ack, bisr_en} per start pulse.
module tb_bisr_job_scheduler;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NPE  = ROWS * COLS;
    localparam int FCW  = $clog2(NPE + 1);

    logic           clk = 1'b0;
    logic           rst, job_req, force_test, clear_err, fsm_rdy, STW_complete;
    logic [NPE-1:0] STW_result_mat, fault_map;
    logic [FCW-1:0] fault_count;
    logic           job_ack, job_done, start_fsm, bisr_en, unrepairable, timeout_err, busy;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    bisr_job_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .TEST_INTERVAL(2), .TIMEOUT(64), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .job_req(job_req), .job_ack(job_ack), .job_done(job_done),
        .force_test(force_test), .clear_err(clear_err), .fsm_rdy(fsm_rdy),
        .STW_complete(STW_complete), .STW_result_mat(STW_result_mat), .start_fsm(start_fsm),
        .bisr_en(bisr_en), .fault_map(fault_map), .fault_count(fault_count),
        .unrepairable(unrepairable), .timeout_err(timeout_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every start pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && start_fsm === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", start_fsm, 1'b0);
            end else begin
                check("launch_ack", job_ack, exp_q[0][1]);
                check("launch_bisr_en", bisr_en, exp_q[0][0]);
                void'(exp_q.pop_front());
            end
        end else if (rst === 1'b1 && job_ack !== 1'b0) begin
            check("ack_without_start", job_ack, 1'b0);
        end
    end

    task automatic wait_start();
        int n;
        n = 0;
        while (start_fsm !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (start_fsm !== 1'b1) check("start_timeout", start_fsm, 1'b1);
    endtask

    // Expect one launch, then play the systolic top: busy for busy_cyc cycles, then ready.
    task automatic serve(input bit is_job, input bit exp_bisr, input int busy_cyc,
                         input logic [NPE-1:0] res, input bit keep_req);
        exp_q.push_back({is_job, exp_bisr});
        wait_start();
        if (is_job) job_req = keep_req;
        fsm_rdy = 1'b0;
        repeat (busy_cyc) @(negedge clk);
        if (!is_job) begin
            STW_result_mat = res;
            STW_complete   = 1'b1;
        end
        fsm_rdy = 1'b1;
        @(negedge clk);
        STW_complete = 1'b0;
        check("done_pulse", job_done, is_job);
    endtask

    initial begin
        rst = 1'b0; job_req = 1'b0; force_test = 1'b0; clear_err = 1'b0;
        fsm_rdy = 1'b1; STW_complete = 1'b0; STW_result_mat = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_outputs", {start_fsm, job_ack, job_done, bisr_en, unrepairable, timeout_err, busy}, 7'd0);
        check("reset_fault_map", fault_map, 16'h0000);
        check("reset_fault_count", fault_count, 5'd0);

        // First boundary is a self-test even with a job waiting.
        job_req = 1'b1;
        rst     = 1'b1;
        serve(1'b0, 1'b1, 4, 16'h0000, 1'b1);
        @(negedge clk);
        check("bisr_en_clean", bisr_en, 1'b0);
        serve(1'b1, 1'b0, 10, 16'h0000, 1'b1);
        serve(1'b1, 1'b0, 10, 16'h0000, 1'b1);

        // Interval reached: self-test finds one fault, repair then stays enabled.
        serve(1'b0, 1'b1, 6, 16'h0001, 1'b1);
        @(negedge clk);
        check("one_fault_count", fault_count, 5'd1);
        check("one_fault_map", fault_map, 16'h0001);
        check("one_fault_unrep", unrepairable, 1'b0);
        check("one_fault_bisr", bisr_en, 1'b1);
        serve(1'b1, 1'b1, 10, 16'h0000, 1'b1);
        serve(1'b1, 1'b1, 10, 16'h0000, 1'b1);

        // Second fault in column 0 is unrepairable.
        serve(1'b0, 1'b1, 6, 16'h0003, 1'b1);
        @(negedge clk);
        check("unrep_flag", unrepairable, 1'b1);
        check("unrep_count", fault_count, 5'd2);
        check("unrep_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("error_no_ack", job_ack, 1'b0);
        end
        job_req   = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clear_busy", busy, 1'b0);
        check("clear_unrep", unrepairable, 1'b0);
        check("clear_keeps_map", fault_map, 16'h0003);
        check("clear_keeps_count", fault_count, 5'd2);
        check("clear_bisr", bisr_en, 1'b1);

        // Asynchronous reset in the middle of a running job.
        job_req = 1'b1;
        exp_q.push_back(2'b11);
        wait_start();
        job_req = 1'b0;
        fsm_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs", {start_fsm, job_ack, job_done, bisr_en, unrepairable, timeout_err, busy}, 7'd0);
        check("async_reset_map", fault_map, 16'h0000);
        check("async_reset_count", fault_count, 5'd0);
        @(negedge clk);
        fsm_rdy = 1'b1;
        job_req = 1'b1;
        rst     = 1'b1;
        serve(1'b0, 1'b1, 4, 16'h0000, 1'b1);
        serve(1'b1, 1'b0, 10, 16'h0000, 1'b0);

        // Systolic top never becomes ready: timeout out of C_LAUNCH.
        @(negedge clk);
        fsm_rdy = 1'b0;
        job_req = 1'b1;
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("c_launch_timeout_cycles", cyc, 65);
        check("c_launch_timeout_busy", busy, 1'b1);
        job_req   = 1'b0;
        fsm_rdy   = 1'b1;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("timeout_cleared", timeout_err, 1'b0);

        // Forced self-test whose completion never arrives: timeout out of T_WAIT.
        force_test = 1'b1;
        exp_q.push_back(2'b01);
        @(negedge clk);
        force_test = 1'b0;
        wait_start();
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t_wait_timeout_cycles", cyc, 64);
        check("t_wait_timeout_busy", busy, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
